// File: rtl/ps_pkg.sv
// ----------------------------------------------------------------------------
// ps_pkg
// Shared definitions for the paralelo_serial_param converter:
//   - ps_state_e          : converter FSM states (SYNC, ACTIVE)
//   - PS_IDLE_SYM_DEFAULT : default idle/comma symbol (8'hBC)
//   - ps_frame_len()      : bit slots per frame (DATA_W, or DATA_W+1 when
//                           the PS_PARITY_EN macro appends a parity slot)
//   - ps_cnt_width()      : counter width able to hold 0..n-1
// Configuration macro: PS_PARITY_EN (adds one even-parity slot per frame).
// ----------------------------------------------------------------------------
package ps_pkg;

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } ps_state_e;

  localparam logic [7:0] PS_IDLE_SYM_DEFAULT = 8'hBC;

  // Number of bit slots in one serial frame.
  function automatic int ps_frame_len(input int data_w);
`ifdef PS_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

  // Width of a counter running over 0..n-1 (never narrower than one bit).
  function automatic int ps_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_shift_reg.sv
// ----------------------------------------------------------------------------
// ps_shift_reg
// Parallel-load / serial-shift register with selectable bit order and an
// optional trailing even-parity slot.
// Ports:
//   clk         : bit-rate clock, rising edge
//   rst_n       : asynchronous active-low reset
//   load        : load load_word this edge (first bit appears on bit_out
//                 on the same edge)
//   load_word   : word to load
//   parity_slot : (PS_PARITY_EN only) this edge emits the parity bit
//   bit_out     : registered serial bit
//   word_out    : registered copy of the last loaded word
// Configuration macro: PS_PARITY_EN.
// ----------------------------------------------------------------------------
module ps_shift_reg
  import ps_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
`ifdef PS_PARITY_EN
  input  logic              parity_slot,
`endif
  output logic              bit_out,
  output logic [DATA_W-1:0] word_out
);

  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] shifted;
  logic              first_bit;
  logic              next_bit;

  // The register always holds the not-yet-sent bits aligned so that the
  // next bit to emit sits one position in from the output end.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign first_bit = load_word[0];
      assign next_bit  = sreg[1];
      assign shifted   = sreg >> 1;
    end else begin : g_msb
      assign first_bit = load_word[DATA_W-1];
      assign next_bit  = sreg[DATA_W-2];
      assign shifted   = sreg << 1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      word_out <= '0;
      bit_out  <= 1'b0;
    end else if (load) begin
      sreg     <= load_word;
      word_out <= load_word;
      bit_out  <= first_bit;
    end else begin
      sreg <= shifted;
`ifdef PS_PARITY_EN
      // Even parity is taken from the held copy of the word, so no extra
      // parity register is needed.
      bit_out <= parity_slot ? (^word_out) : next_bit;
`else
      bit_out <= next_bit;
`endif
    end
  end

endmodule

// File: rtl/paralelo_serial_param.sv
// ----------------------------------------------------------------------------
// paralelo_serial_param
// Parallel-to-serial converter on a single bit-rate clock. An internal bit
// counter marks word slots; after reset SYNC_WORDS idle symbols are sent
// before the ready/valid word handshake opens.
// Ports:
//   clk_32f    : bit-rate clock, rising edge
//   reset_L    : asynchronous active-low reset
//   data_in    : parallel word to transmit
//   valid_in   : data_in holds a word
//   ready_out  : last bit slot of a frame while ACTIVE (transfer slot)
//   data_out   : registered serial bit
//   data2send  : word currently being shifted
//   idle_out   : current frame carries IDLE_SYM
//   active_out : FSM is in ACTIVE
// Configuration macro: PS_PARITY_EN (one even-parity slot after each word).
// ----------------------------------------------------------------------------
module paralelo_serial_param
  import ps_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(PS_IDLE_SYM_DEFAULT),
  parameter int                SYNC_WORDS = 4,
  parameter int                LSB_FIRST  = 0
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              data_out,
  output logic [DATA_W-1:0] data2send,
  output logic              idle_out,
  output logic              active_out
);

  localparam int FRAME  = ps_frame_len(DATA_W);
  localparam int CNT_W  = ps_cnt_width(FRAME);
  localparam int IDLE_W = ps_cnt_width(SYNC_WORDS + 1);

  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(FRAME - 1);
  localparam logic [IDLE_W-1:0] LAST_SYNC = IDLE_W'(SYNC_WORDS - 1);

  ps_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              load;
  logic              accept;
  logic [DATA_W-1:0] load_word;

  // Reset parks bit_cnt on the last slot so the first edge after release
  // is a load edge.
  assign load       = (bit_cnt == LAST_SLOT);
  assign active_out = (state == ACTIVE);
  assign ready_out  = active_out && load;
  assign accept     = valid_in && ready_out;
  assign load_word  = accept ? data_in : IDLE_SYM;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt <= LAST_SLOT;
    end else if (load) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Every SYNC load counts one idle word; the load that sends the last sync
  // word also opens the handshake. ACTIVE is only left through reset.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state    <= SYNC;
      idle_cnt <= '0;
      idle_out <= 1'b0;
    end else if (load) begin
      idle_out <= !accept;
      if (state == SYNC) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
        if (idle_cnt == LAST_SYNC) begin
          state <= ACTIVE;
        end
      end
    end
  end

`ifdef PS_PARITY_EN
  logic parity_slot;

  // Next edge fills the slot right after the last data bit.
  assign parity_slot = (bit_cnt == CNT_W'(DATA_W - 1));
`endif

  ps_shift_reg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk         (clk_32f),
    .rst_n       (reset_L),
    .load        (load),
    .load_word   (load_word),
`ifdef PS_PARITY_EN
    .parity_slot (parity_slot),
`endif
    .bit_out     (data_out),
    .word_out    (data2send)
  );

endmodule

// File: tb/tb_paralelo_serial_param.sv
// ----------------------------------------------------------------------------
// tb_paralelo_serial_param
// Directed bench for paralelo_serial_param: an MSB-first and an LSB-first
// instance share stimulus. Frame length follows the PS_PARITY_EN macro.
// ----------------------------------------------------------------------------
module tb_paralelo_serial_param;

`ifdef PS_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic       valid_in;
  logic [7:0] data_in;

  logic       data_out_m, ready_m, idle_m, active_m;
  logic [7:0] d2s_m;
  logic       data_out_l, ready_l, idle_l, active_l;
  logic [7:0] d2s_l;

  int checks = 0;
  int passed = 0;

  logic [5:0] got;
  logic [5:0] exp;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_param #(
    .DATA_W(8), .IDLE_SYM(8'hBC), .SYNC_WORDS(4), .LSB_FIRST(0)
  ) dut_msb (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_m), .data_out(data_out_m), .data2send(d2s_m),
    .idle_out(idle_m), .active_out(active_m)
  );

  paralelo_serial_param #(
    .DATA_W(8), .IDLE_SYM(8'hBC), .SYNC_WORDS(4), .LSB_FIRST(1)
  ) dut_lsb (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_l), .data_out(data_out_l), .data2send(d2s_l),
    .idle_out(idle_l), .active_out(active_l)
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) step();
    checks++;
    if ({data_out_m, ready_m, idle_m, active_m, data_out_l, ready_l, idle_l, active_l} !== 8'b0)
      $display("[TB] FAIL reset_bits: got %b expected %b",
               {data_out_m, ready_m, idle_m, active_m, data_out_l, ready_l, idle_l, active_l}, 8'b0);
    else passed++;
    checks++;
    if ({d2s_m, d2s_l} !== 16'h0000)
      $display("[TB] FAIL reset_data2send: got %h expected %h", {d2s_m, d2s_l}, 16'h0000);
    else passed++;
  endtask

  // Four idle frames after release; valid_in is held high with A5 the whole
  // time and must be ignored until the first ready slot, where it drops.
  task automatic test_sync();
    logic [7:0] w;
    w        = 8'hBC;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    reset_L  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < FRAME; s++) begin
        step();
        got = {data_out_m, data_out_l, ready_m, ready_l, active_m, active_l};
        exp[5] = (s < 8) ? w[7-s] : 1'b1;
        exp[4] = (s < 8) ? w[s]   : 1'b1;
        exp[3] = (f == 3) && (s == FRAME - 1);
        exp[2] = exp[3];
        exp[1] = (f == 3);
        exp[0] = (f == 3);
        checks++;
        if (got !== exp)
          $display("[TB] FAIL sync f%0d s%0d: got %b expected %b", f, s, got, exp);
        else passed++;
        if (s == 0) begin
          checks++;
          if ({d2s_m, d2s_l, idle_m, idle_l} !== {8'hBC, 8'hBC, 2'b11})
            $display("[TB] FAIL sync_word f%0d: got %h expected %h",
                     f, {d2s_m, d2s_l, idle_m, idle_l}, {8'hBC, 8'hBC, 2'b11});
          else passed++;
        end
      end
    end
    valid_in = 1'b0;
  endtask

  // valid_in was low in the ready slot: exactly one idle frame follows.
  task automatic test_idle_frame();
    logic [7:0] w;
    w = 8'hBC;
    for (int s = 0; s < FRAME; s++) begin
      step();
      got = {data_out_m, data_out_l, ready_m, ready_l, active_m, active_l};
      exp[5] = (s < 8) ? w[7-s] : 1'b1;
      exp[4] = (s < 8) ? w[s]   : 1'b1;
      exp[3] = (s == FRAME - 1);
      exp[2] = exp[3];
      exp[1:0] = 2'b11;
      checks++;
      if (got !== exp)
        $display("[TB] FAIL idle_frame s%0d: got %b expected %b", s, got, exp);
      else passed++;
      if (s == 0) begin
        checks++;
        if ({d2s_m, idle_m, d2s_l, idle_l} !== {8'hBC, 1'b1, 8'hBC, 1'b1})
          $display("[TB] FAIL idle_word: got %h expected %h",
                   {d2s_m, idle_m, d2s_l, idle_l}, {8'hBC, 1'b1, 8'hBC, 1'b1});
        else passed++;
      end
    end
    valid_in = 1'b1;
    data_in  = 8'hA5;
  endtask

  // A5, 01, FF back to back, then valid_in drops so an idle frame follows.
  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic       par   [3];
    logic [7:0] w;
    words = '{8'hA5, 8'h01, 8'hFF};
    par   = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      w = words[k];
      for (int s = 0; s < FRAME; s++) begin
        step();
        if (s == 0) begin
          if (k < 2) data_in = words[k+1];
          else valid_in = 1'b0;
        end
        got = {data_out_m, data_out_l, ready_m, ready_l, active_m, active_l};
        exp[5] = (s < 8) ? w[7-s] : par[k];
        exp[4] = (s < 8) ? w[s]   : par[k];
        exp[3] = (s == FRAME - 1);
        exp[2] = exp[3];
        exp[1:0] = 2'b11;
        checks++;
        if (got !== exp)
          $display("[TB] FAIL b2b w%0d s%0d: got %b expected %b", k, s, got, exp);
        else passed++;
        if (s == 0) begin
          checks++;
          if ({d2s_m, idle_m, d2s_l, idle_l} !== {w, 1'b0, w, 1'b0})
            $display("[TB] FAIL b2b_word w%0d: got %h expected %h",
                     k, {d2s_m, idle_m, d2s_l, idle_l}, {w, 1'b0, w, 1'b0});
          else passed++;
        end
      end
    end
  endtask

  // Reset lands in the middle of an A5 frame and must clear at once.
  task automatic test_reset_mid();
    repeat (3) step();
    checks++;
    if ({d2s_m, d2s_l} !== 16'hA5A5)
      $display("[TB] FAIL mid_loaded: got %h expected %h", {d2s_m, d2s_l}, 16'hA5A5);
    else passed++;
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({data_out_m, ready_m, idle_m, active_m, d2s_m, data_out_l, ready_l, idle_l, active_l, d2s_l} !== 24'h0)
      $display("[TB] FAIL mid_reset_immediate: got %h expected %h",
               {data_out_m, ready_m, idle_m, active_m, d2s_m, data_out_l, ready_l, idle_l, active_l, d2s_l}, 24'h0);
    else passed++;
    repeat (2) step();
    checks++;
    if ({data_out_m, ready_m, idle_m, active_m, d2s_m, data_out_l, ready_l, idle_l, active_l, d2s_l} !== 24'h0)
      $display("[TB] FAIL mid_reset_held: got %h expected %h",
               {data_out_m, ready_m, idle_m, active_m, d2s_m, data_out_l, ready_l, idle_l, active_l, d2s_l}, 24'h0);
    else passed++;
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync();
    test_idle_frame();
    test_back_to_back();
    test_idle_frame();
    test_reset_mid();
    test_sync();
    test_idle_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
